obstacle_spawner: RTL

- Sits directly upstream of the obstacle slot instances.
- Decides when a new obstacle enters, which obstacle type it is, and which free slot receives it.
- Drives each slot's start and typ inputs.
- Reads back each slot's occupancy, position, width and gap so that spacing follows the gap each slot computed.

---
 rtl/obstacle_pkg.sv | 19 +
 rtl/spawner_pkg.sv | 18 +
 rtl/obstacle_type_picker.sv | 47 ++++
 rtl/obstacle_spawner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Obstacle types and playfield constants shared by the slots
// and the spawner.
package obstacle_pkg;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    CACTUS_SMALL = 2'd1,
    CACTUS_LARGE = 2'd2,
    PTERODACTYL  = 2'd3
  } type_t;

  localparam int SPEED_SCALE = 1024;
  localparam int GAME_WIDTH  = 640;

  localparam logic [14:0] MIN_SPEED [4] = '{
    15'd0, 15'd0, 15'd0, 15'd8704
  };

endpackage

// File: rtl/spawner_pkg.sv
// Spawner FSM states and default tuning.
package spawner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEARING,
    READY,
    DECIDE,
    REQUEST,
    CRASHED
  } state_t;

  localparam int CLEAR_FRAMES_DEF = 180;
  localparam int MAX_DUP_DEF      = 2;
  localparam int DUP_W            = 4;
  localparam int CNT_W            = 16;

endpackage

// File: rtl/obstacle_type_picker.sv
// Maps a random value to an obstacle type, steering away from
// over-repeated types and from pterodactyls at low speed.
module obstacle_type_picker
  import obstacle_pkg::*;
  import spawner_pkg::*;
#(
  parameter int MAX_DUPLICATION = MAX_DUP_DEF
) (
  input  logic [10:0]      rng,
  input  type_t            last_type,
  input  logic [DUP_W-1:0] dup_count,
  input  logic [14:0]      speed,
  output type_t            typ
);

  type_t c0, c1, c2;
  logic  bad0, bad1;

  function automatic type_t rotate(input type_t t);
    case (t)
      CACTUS_SMALL: return CACTUS_LARGE;
      CACTUS_LARGE: return PTERODACTYL;
      default:      return CACTUS_SMALL;
    endcase
  endfunction

  function automatic logic invalid(
    input type_t            t,
    input type_t            last,
    input logic [DUP_W-1:0] dup,
    input logic [14:0]      spd
  );
    return (t == last && dup >= DUP_W'(MAX_DUPLICATION)) ||
           (t == PTERODACTYL && spd < MIN_SPEED[PTERODACTYL]);
  endfunction

  // Two rotations always reach a legal type.
  always_comb begin
    c0   = type_t'(2'(rng % 11'd3) + 2'd1);
    c1   = rotate(c0);
    c2   = rotate(c1);
    bad0 = invalid(c0, last_type, dup_count, speed);
    bad1 = invalid(c1, last_type, dup_count, speed);
    typ  = bad0 ? (bad1 ? c2 : c1) : c0;
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Chooses when, what and where the next obstacle spawns.
// Optional counters: define OBSTACLE_SPAWNER_STATS_EN.
module obstacle_spawner
  import obstacle_pkg::*;
  import spawner_pkg::*;
#(
  parameter int SLOT_COUNT      = 3,
  parameter int CLEAR_FRAMES    = CLEAR_FRAMES_DEF,
  parameter int MAX_DUPLICATION = MAX_DUP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   update,
  input  logic                   start_game,
  input  logic                   crash,
  input  logic [14:0]            speed,
  input  logic [10:0]            rng_data,
  input  logic [SLOT_COUNT-1:0]  slot_active,
  input  logic signed [10:0]     slot_x_pos [SLOT_COUNT],
  input  logic [9:0]             slot_width [SLOT_COUNT],
  input  logic [10:0]            slot_gap   [SLOT_COUNT],
  output logic [SLOT_COUNT-1:0]  start,
  output type_t                  typ [SLOT_COUNT],
  output logic                   spawning
`ifdef OBSTACLE_SPAWNER_STATS_EN
  ,
  output logic [15:0]            spawn_count,
  output logic [15:0]            reject_count
`endif
);

  localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [10:0]            rng_q, rng_d;
  logic [SLOT_COUNT-1:0]  start_q, start_d;
  type_t                  typ_q [SLOT_COUNT];
  type_t                  typ_d [SLOT_COUNT];
  type_t                  last_type_q, last_type_d;
  type_t                  req_type_q, req_type_d;
  logic [DUP_W-1:0]       dup_q, dup_d;
  logic [SW-1:0]          last_slot_q, last_slot_d;
  logic [SW-1:0]          req_slot_q, req_slot_d;

  type_t                  pick;
  logic                   free_found;
  logic [SW-1:0]          free_idx;
  logic signed [12:0]     far_sum;
  logic                   gap_ok;

  obstacle_type_picker #(
    .MAX_DUPLICATION(MAX_DUPLICATION)
  ) u_picker (
    .rng      (rng_q),
    .last_type(last_type_q),
    .dup_count(dup_q),
    .speed    (speed),
    .typ      (pick)
  );

  // Right edge of the newest obstacle plus the gap it asked for.
  assign far_sum = {{2{slot_x_pos[last_slot_q][10]}}, slot_x_pos[last_slot_q]}
                 + {3'b000, slot_width[last_slot_q]}
                 + {2'b00, slot_gap[last_slot_q]};
  assign gap_ok  = !slot_active[last_slot_q] ||
                   (far_sum < $signed(13'(GAME_WIDTH)));

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rng_d       = rng_q;
    start_d     = start_q;
    typ_d       = typ_q;
    last_type_d = last_type_q;
    req_type_d  = req_type_q;
    dup_d       = dup_q;
    last_slot_d = last_slot_q;
    req_slot_d  = req_slot_q;
    if (crash) begin
      state_d = CRASHED;
      start_d = '0;
    end else begin
      unique case (state_q)
        IDLE, CRASHED: begin
          if (start_game) begin
            state_d     = CLEARING;
            cnt_d       = '0;
            last_type_d = NONE;
            dup_d       = '0;
          end
        end
        CLEARING: begin
          if (update) begin
            if (cnt_q == CNT_W'(CLEAR_FRAMES - 1)) state_d = READY;
            else cnt_d = cnt_q + CNT_W'(1);
          end
        end
        READY: begin
          if (update && gap_ok) begin
            rng_d   = rng_data;
            state_d = DECIDE;
          end
        end
        DECIDE: begin
          state_d = READY;
          if (free_found) begin
            start_d[free_idx] = 1'b1;
            typ_d[free_idx]   = pick;
            req_slot_d        = free_idx;
            req_type_d        = pick;
            state_d           = REQUEST;
          end
        end
        REQUEST: begin
          if (slot_active[req_slot_q]) begin
            start_d     = '0;
            last_slot_d = req_slot_q;
            last_type_d = req_type_q;
            state_d     = READY;
            if (req_type_q != last_type_q) dup_d = DUP_W'(1);
            else if (dup_q < DUP_W'(MAX_DUPLICATION)) dup_d = dup_q + DUP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rng_q       <= '0;
      start_q     <= '0;
      last_type_q <= NONE;
      req_type_q  <= NONE;
      dup_q       <= '0;
      last_slot_q <= '0;
      req_slot_q  <= '0;
      for (int i = 0; i < SLOT_COUNT; i++) typ_q[i] <= NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rng_q       <= rng_d;
      start_q     <= start_d;
      last_type_q <= last_type_d;
      req_type_q  <= req_type_d;
      dup_q       <= dup_d;
      last_slot_q <= last_slot_d;
      req_slot_q  <= req_slot_d;
      typ_q       <= typ_d;
    end
  end

  assign start    = start_q;
  assign typ      = typ_q;
  assign spawning = |start_q;

`ifdef OBSTACLE_SPAWNER_STATS_EN
  logic [15:0] spawn_q, reject_q;
  logic        acc_ev, rej_ev, clr_ev;

  assign acc_ev = !crash && state_q == REQUEST && slot_active[req_slot_q];
  assign rej_ev = !crash && state_q == DECIDE && !free_found;
  assign clr_ev = !crash && start_game &&
                  (state_q == IDLE || state_q == CRASHED);

  always_ff @(posedge clk) begin
    if (rst || clr_ev) begin
      spawn_q  <= '0;
      reject_q <= '0;
    end else begin
      if (acc_ev && spawn_q != 16'hFFFF) spawn_q <= spawn_q + 16'd1;
      if (rej_ev && reject_q != 16'hFFFF) reject_q <= reject_q + 16'd1;
    end
  end

  assign spawn_count  = spawn_q;
  assign reject_count = reject_q;
`endif

endmodule
